// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for an N-stage in-order pipeline. It resolves per-stage stall and flush
// requests, a multi-cycle unit window and a drain/halt sequence into per-stage-register enables.
module pipeline_hazard_ctrl #(
    parameter int N_STAGES = 5,
    parameter int MC_STAGE = 2,
    parameter int CNT_W    = 4,
    parameter int PERF_W   = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_STAGES-1:0] stall_req,
    input  logic [N_STAGES-1:0] flush_req,
    input  logic                mc_start,
    input  logic [CNT_W-1:0]    mc_cycles,
    input  logic                halt_req,
    output logic [N_STAGES-1:0] stall,
    output logic [N_STAGES-1:0] flush,
    output logic                halted,
    output logic                mc_busy,
    output logic                mc_overlap_err,
    output logic [PERF_W-1:0]   perf_stall,
    output logic [PERF_W-1:0]   perf_flush
);
    localparam int SW = $clog2(N_STAGES);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

    state_e              state_q, state_d;
    logic [SW-1:0]       drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0]    mc_cnt_q, mc_cnt_d;
    logic                err_q, err_d;
    logic                halted_q, halted_d;
    logic [PERF_W-1:0]   perf_stall_q, perf_stall_d;
    logic [PERF_W-1:0]   perf_flush_q, perf_flush_d;

    logic                s_req_any, f_any, s_any;
    logic [SW-1:0]       s_req_idx, f_idx, s_idx;
    logic                mc_abort, mc_stall, stall_win;
    logic [N_STAGES-1:0] stall_c, flush_c;

    always_comb begin
        s_req_any = 1'b0;
        s_req_idx = '0;
        f_any     = 1'b0;
        f_idx     = '0;
        for (int i = 1; i < N_STAGES; i++) begin
            if (stall_req[i]) begin
                s_req_any = 1'b1;
                s_req_idx = SW'(i);
            end
            if (flush_req[i]) begin
                f_any = 1'b1;
                f_idx = SW'(i);
            end
        end

        // An abort needs a flush older than the MC stage that also beats every explicit stall;
        // since the MC stall sits below such a flush, it can never change that outcome.
        mc_abort = (state_q != HALTED) && f_any && (int'(f_idx) > MC_STAGE) &&
                   (!s_req_any || (f_idx > s_req_idx));
        mc_stall = ((mc_start && (mc_cycles != '0)) || (mc_cnt_q != '0)) && !mc_abort;

        s_any = s_req_any || mc_stall;
        s_idx = s_req_idx;
        if (mc_stall && (!s_req_any || (int'(s_req_idx) < MC_STAGE)))
            s_idx = SW'(MC_STAGE);

        stall_win = s_any && (!f_any || (f_idx <= s_idx));

        stall_c = '0;
        flush_c = '0;
        for (int i = 0; i < N_STAGES; i++) begin
            if (stall_win) begin
                stall_c[i] = (i <= int'(s_idx));
                flush_c[i] = (i == int'(s_idx) + 1);
            end else if (f_any) begin
                flush_c[i] = (i >= 1) && (i <= int'(f_idx));
            end
        end

        if (state_q == DRAIN && !stall_win) begin
            stall_c[0] = 1'b1;
            flush_c[1] = 1'b1;
        end
        if (state_q == HALTED) begin
            stall_c = '1;
            flush_c = '0;
        end
        if (reset) begin
            stall_c = '0;
            flush_c = '0;
        end
    end

    always_comb begin
        mc_cnt_d = mc_cnt_q;
        if (mc_abort)
            mc_cnt_d = '0;
        else if (mc_start && mc_cnt_q == '0)
            mc_cnt_d = (mc_cycles == '0) ? '0 : mc_cycles - CNT_W'(1);
        else if (mc_cnt_q != '0)
            mc_cnt_d = mc_cnt_q - CNT_W'(1);

        err_d = err_q || (mc_start && mc_cnt_q != '0);

        perf_stall_d = perf_stall_q;
        if ((|stall_c) && !(&perf_stall_q))
            perf_stall_d = perf_stall_q + PERF_W'(1);
        perf_flush_d = perf_flush_q;
        if ((|flush_c) && !(&perf_flush_q))
            perf_flush_d = perf_flush_q + PERF_W'(1);

        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            RUN: begin
                if (halt_req) begin
                    state_d     = DRAIN;
                    drain_cnt_d = SW'(N_STAGES - 1);
                end
            end
            DRAIN: begin
                if (!halt_req) begin
                    state_d = RUN;
                end else if (!stall_win) begin
                    // The decrement that reaches zero is the last drain cycle.
                    drain_cnt_d = drain_cnt_q - SW'(1);
                    if (drain_cnt_q <= SW'(1)) begin
                        state_d     = HALTED;
                        drain_cnt_d = '0;
                    end
                end
            end
            HALTED: begin
                if (!halt_req)
                    state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        halted_d = (state_d == HALTED);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            drain_cnt_q  <= '0;
            mc_cnt_q     <= '0;
            err_q        <= 1'b0;
            halted_q     <= 1'b0;
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            state_q      <= state_d;
            drain_cnt_q  <= drain_cnt_d;
            mc_cnt_q     <= mc_cnt_d;
            err_q        <= err_d;
            halted_q     <= halted_d;
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign stall          = stall_c;
    assign flush          = flush_c;
    assign halted         = halted_q;
    assign mc_busy        = mc_stall && !reset;
    assign mc_overlap_err = err_q;
    assign perf_stall     = perf_stall_q;
    assign perf_flush     = perf_flush_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a table of single-cycle resolution vectors plus
// hand-written multi-cycle sequences (MC window, abort, overlap, drain/halt, reset, saturation).
module tb_pipeline_hazard_ctrl;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] stall_req, flush_req;
    logic       mc_start, halt_req;
    logic [3:0] mc_cycles;

    logic [4:0]  stall, flush, stall4, flush4;
    logic        halted, mc_busy, err, halted4, busy4, err4;
    logic [15:0] perf_stall, perf_flush;
    logic [3:0]  perf_stall4, perf_flush4;

    int errors = 0;
    int checks = 0;

    pipeline_hazard_ctrl #(.N_STAGES(5), .MC_STAGE(2), .CNT_W(4), .PERF_W(16)) dut (
        .clock(clock), .reset(reset), .stall_req(stall_req), .flush_req(flush_req),
        .mc_start(mc_start), .mc_cycles(mc_cycles), .halt_req(halt_req),
        .stall(stall), .flush(flush), .halted(halted), .mc_busy(mc_busy),
        .mc_overlap_err(err), .perf_stall(perf_stall), .perf_flush(perf_flush)
    );

    pipeline_hazard_ctrl #(.N_STAGES(5), .MC_STAGE(2), .CNT_W(4), .PERF_W(4)) dut4 (
        .clock(clock), .reset(reset), .stall_req(stall_req), .flush_req(flush_req),
        .mc_start(mc_start), .mc_cycles(mc_cycles), .halt_req(halt_req),
        .stall(stall4), .flush(flush4), .halted(halted4), .mc_busy(busy4),
        .mc_overlap_err(err4), .perf_stall(perf_stall4), .perf_flush(perf_flush4)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic [4:0] sr;
        logic [4:0] fr;
        logic [4:0] es;
        logic [4:0] ef;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic drive(input logic [4:0] sr, input logic [4:0] fr, input logic ms,
                         input logic [3:0] mc, input logic hr);
        stall_req = sr;
        flush_req = fr;
        mc_start  = ms;
        mc_cycles = mc;
        halt_req  = hr;
        #1;
    endtask

    initial begin
        vec_t vt[9];
        int   exp_ps, exp_pf;

        vt[0] = '{"stall1",        5'b00010, 5'b00000, 5'b00011, 5'b00100};
        vt[1] = '{"stall4",        5'b10000, 5'b00000, 5'b11111, 5'b00000};
        vt[2] = '{"tie_stall",     5'b00010, 5'b00010, 5'b00011, 5'b00100};
        vt[3] = '{"flush_older",   5'b00010, 5'b00100, 5'b00000, 5'b00110};
        vt[4] = '{"idle",          5'b00000, 5'b00000, 5'b00000, 5'b00000};
        vt[5] = '{"bit0_ignored",  5'b00001, 5'b00001, 5'b00000, 5'b00000};
        vt[6] = '{"flush4",        5'b00100, 5'b10000, 5'b00000, 5'b11110};
        vt[7] = '{"stall3_vs_f2",  5'b01000, 5'b00100, 5'b01111, 5'b10000};
        vt[8] = '{"f3_vs_stall2",  5'b00100, 5'b01000, 5'b00000, 5'b01110};

        drive(5'b00010, 5'b00100, 1'b0, 4'd0, 1'b0);
        chk("reset_stall", stall, 0);
        chk("reset_flush", flush, 0);
        chk("reset_halted", halted, 0);
        chk("reset_perf", {perf_stall, perf_flush}, 0);
        tick();
        tick();
        reset = 1'b0;

        exp_ps = 0;
        exp_pf = 0;
        for (int i = 0; i < 9; i++) begin
            drive(vt[i].sr, vt[i].fr, 1'b0, 4'd0, 1'b0);
            chk({vt[i].name, "_stall"}, stall, vt[i].es);
            chk({vt[i].name, "_flush"}, flush, vt[i].ef);
            if (vt[i].es != 0) exp_ps++;
            if (vt[i].ef != 0) exp_pf++;
            tick();
        end
        drive(0, 0, 1'b0, 4'd0, 1'b0);
        chk("perf_stall_table", perf_stall, exp_ps);
        chk("perf_flush_table", perf_flush, exp_pf);

        // Three-cycle MC window
        drive(0, 0, 1'b1, 4'd3, 1'b0);
        chk("mc3_c0_stall", stall, 5'b00111);
        chk("mc3_c0_flush", flush, 5'b01000);
        chk("mc3_c0_busy", mc_busy, 1);
        tick();
        drive(0, 0, 1'b0, 4'd0, 1'b0);
        chk("mc3_c1_stall", stall, 5'b00111);
        tick();
        chk("mc3_c2_stall", stall, 5'b00111);
        chk("mc3_c2_flush", flush, 5'b01000);
        tick();
        chk("mc3_c3_stall", stall, 0);
        chk("mc3_c3_busy", mc_busy, 0);

        drive(0, 0, 1'b1, 4'd0, 1'b0);
        chk("mc0_stall", stall, 0);
        chk("mc0_busy", mc_busy, 0);
        tick();

        // Abort of an active window by an older flush
        drive(0, 0, 1'b1, 4'd3, 1'b0);
        tick();
        drive(0, 5'b01000, 1'b0, 4'd0, 1'b0);
        chk("abort_flush", flush, 5'b01110);
        chk("abort_stall", stall, 0);
        tick();
        drive(0, 0, 1'b0, 4'd0, 1'b0);
        chk("abort_busy_next", mc_busy, 0);
        chk("abort_stall_next", stall, 0);

        // Overlapping mc_start is ignored and flagged
        drive(0, 0, 1'b1, 4'd3, 1'b0);
        tick();
        drive(0, 0, 1'b1, 4'd5, 1'b0);
        chk("ovl_err_before", err, 0);
        chk("ovl_stall", stall, 5'b00111);
        tick();
        drive(0, 0, 1'b0, 4'd0, 1'b0);
        chk("ovl_err_set", err, 1);
        chk("ovl_last_stall", stall, 5'b00111);
        tick();
        chk("ovl_done_stall", stall, 0);
        chk("ovl_err_sticky", err, 1);
        reset = 1'b1;
        #1;
        chk("ovl_err_reset", err, 0);
        tick();
        reset = 1'b0;

        // Drain with one stall-wins cycle, then halt
        drive(0, 0, 1'b0, 4'd0, 1'b1);
        chk("halt_run_stall", stall, 0);
        tick();
        drive(5'b01000, 0, 1'b0, 4'd0, 1'b1);
        chk("drain_sw_stall", stall, 5'b01111);
        chk("drain_sw_flush", flush, 5'b10000);
        tick();
        drive(0, 0, 1'b0, 4'd0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            chk("drain_stall", stall, 5'b00001);
            chk("drain_flush", flush, 5'b00010);
            chk("drain_halted", halted, 0);
            tick();
        end
        chk("halted_flag", halted, 1);
        chk("halted_stall", stall, 5'b11111);
        drive(5'b00010, 5'b10000, 1'b0, 4'd0, 1'b1);
        chk("halted_ign_stall", stall, 5'b11111);
        chk("halted_ign_flush", flush, 0);
        tick();
        drive(0, 0, 1'b0, 4'd0, 1'b0);
        chk("halted_hold", halted, 1);
        tick();
        chk("resume_halted", halted, 0);
        chk("resume_stall", stall, 0);

        // Reset mid-MC window
        drive(0, 0, 1'b1, 4'd5, 1'b0);
        tick();
        drive(5'b00010, 0, 1'b0, 4'd0, 1'b0);
        reset = 1'b1;
        #1;
        chk("rst_mc_stall", stall, 0);
        chk("rst_mc_flush", flush, 0);
        chk("rst_mc_busy", mc_busy, 0);
        chk("rst_mc_perf", {perf_stall, perf_flush}, 0);
        tick();
        reset = 1'b0;
        drive(0, 0, 1'b0, 4'd0, 1'b0);
        chk("rst_mc_cleared", stall, 0);

        // Reset mid-drain
        drive(0, 0, 1'b0, 4'd0, 1'b1);
        tick();
        tick();
        chk("pre_rst_drain", stall, 5'b00001);
        reset = 1'b1;
        #1;
        chk("rst_drain_stall", stall, 0);
        chk("rst_drain_flush", flush, 0);
        tick();
        reset = 1'b0;
        drive(0, 0, 1'b0, 4'd0, 1'b0);
        chk("rst_drain_run", stall, 0);
        chk("rst_drain_halted", halted, 0);

        // Saturation: 20 stall cycles into a 4-bit counter
        drive(5'b00010, 0, 1'b0, 4'd0, 1'b0);
        for (int k = 0; k < 20; k++) tick();
        drive(0, 0, 1'b0, 4'd0, 1'b0);
        chk("sat4_stall", perf_stall4, 15);
        chk("sat4_flush", perf_flush4, 15);
        chk("wide_stall", perf_stall, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
